lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store execution unit at the far end of the load/store buffer's issue interface.
- Accepts one memory op at a time from the LSB and serialises it into byte accesses on the memory-controller port.
- Sign- or zero-extends load data and broadcasts the result with its RoB id on the common result bus.
- Raises busy so the LSB holds further issues until the unit is idle again.

Parameters:
- ADDR_W, 32, address and data width of LSB/CDB ports.
- ROB_ID_W, 5, RoB tag width; 0 means "no tag".

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global ready; low freezes all state
- en_signal_from_lsb  input  1  request valid, one cycle per op
- inst_name_from_lsb  input  6  op code: `LB,`LH,`LW,`LBU,`LHU,`SB,`SH,`SW
- mem_addr_from_lsb  input  32  effective byte address
- store_value_from_lsb  input  32  store data; low bytes used
- rob_id_from_lsb  input  5  destination RoB tag
- busy_to_lsb  output  1  unit cannot accept a new op
- valid_to_cdb  output  1  load result valid, one-cycle pulse
- result_to_cdb  output  32  extended load data
- rob_id_to_cdb  output  5  tag of the result
- mem_en_to_mc  output  1  byte request valid
- mem_wr_to_mc  output  1  1 = write byte, 0 = read byte
- mem_addr_to_mc  output  32  byte address
- mem_data_to_mc  output  8  write byte
- mem_data_from_mc  input  8  read byte, valid with done
- mem_done_from_mc  input  1  current byte completed
- rollback_flag_from_rob  input  1  misprediction flush

Behaviour:
- Reset (rst_in=0, async): state IDLE; all outputs 0; internal op, addr, data, byte counter and kill flag cleared.
- rdy_in=0: no register changes. Outputs hold their values; a valid_to_cdb pulse in progress is held, not repeated on release.
- busy_to_lsb = (state != IDLE) || en_signal_from_lsb. This is combinational, so a request visible this cycle blocks the LSB's registered issue for the next cycle.
- States and transitions:
  - IDLE -> ACCESS on en_signal_from_lsb. Latch op, addr, store value and rob_id, and set byte count from the op: B ops 1, H ops 2, W ops 4.
  - If a load request arrives together with rollback_flag_from_rob, it is dropped: stay IDLE, no output.
  - A store request arrives only after commit, so it is accepted regardless of rollback.
  - ACCESS: mem_en_to_mc=1. Address is base+k, where k counts up from 0 and wraps modulo 2^32. mem_wr_to_mc=is_store; mem_data_to_mc = byte k of the store value (little-endian).
  - Address, wr and data stay stable until mem_done_from_mc is sampled high.
  - On done: loads write mem_data_from_mc into byte k of the result register, then k increments. If it was the last byte, go to DONE.
- DONE (one cycle):
  - Load not killed: valid_to_cdb=1 with result_to_cdb and rob_id_to_cdb.
  - Store or killed load: no pulse.
  - In both cases mem_en_to_mc=0, then return to IDLE.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- Rollback during a load in ACCESS: set kill. The outstanding byte still completes, remaining bytes are skipped, then go to DONE with valid suppressed. Rollback sampled in the same cycle as DONE also suppresses valid.
- Rollback never affects a store in flight.
- Latency: with done returned in the same cycle as mem_en, an op accepted at edge 0 gets a W-load result in cycle 5, an H-load in cycle 3 and a B-load in cycle 2. Each extra memory wait cycle adds one.
- No alignment check; unaligned addresses are walked byte by byte.
- mem_done_from_mc outside ACCESS is ignored.

Decomposition:
- Op encodings (`LB..`SW, `LHU as load/store boundary) and `RAM_IO_PORT stay in the shared defines include; the unit adds no new global constants.
- One natural sub-module: lsu_load_ext, a combinational op plus raw 32-bit value to extended result.
- The FSM and byte sequencing stay in lsu.

Test Plan:
- LW at 0x1000, memory bytes 78 56 34 12, done every cycle -> mem addrs 0x1000..0x1003 with wr=0; valid in cycle 5 with result 0x12345678 and rob_id 3; busy high from the request cycle to DONE.
- LB at 0x20 with byte 0x80, and LBU at the same address -> results 0xFFFFFF80 and 0x00000080; LH of bytes FF 7F -> 0x00007FFF.
- SH addr 0x104, value 0xAABBCCDD, done delayed 2 cycles per byte -> writes DD@0x104 then CC@0x105; no valid pulse; busy drops after DONE.
- LW issued, rollback on the second byte's done cycle -> byte 2 still completes, no further mem_en, no valid pulse, IDLE two cycles later; a new LB accepted immediately after.
- rst_in pulled low mid-SW with mem_en high -> all outputs 0 asynchronously; after release the unit is IDLE and busy_to_lsb=0.
- en_signal_from_lsb with an LW together with rollback -> not accepted, mem_en stays 0. Same case with an SW -> accepted and written.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared op encodings, FSM state type and op-classification helpers for the
// load/store execution unit.
package lsu_pkg;

    localparam int OP_W = 6;

    // Memory op encodings; every code from LB up to LHU is a load, above it a store.
    localparam logic [OP_W-1:0] OP_LB  = 6'd11;
    localparam logic [OP_W-1:0] OP_LH  = 6'd12;
    localparam logic [OP_W-1:0] OP_LW  = 6'd13;
    localparam logic [OP_W-1:0] OP_LBU = 6'd14;
    localparam logic [OP_W-1:0] OP_LHU = 6'd15;
    localparam logic [OP_W-1:0] OP_SB  = 6'd16;
    localparam logic [OP_W-1:0] OP_SH  = 6'd17;
    localparam logic [OP_W-1:0] OP_SW  = 6'd18;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } lsu_state_t;

    // True for any load op.
    function automatic logic is_load_op(input logic [OP_W-1:0] op);
        return (op >= OP_LB) && (op <= OP_LHU);
    endfunction

    // Number of byte accesses the op needs on the memory-controller port.
    function automatic logic [2:0] byte_count(input logic [OP_W-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            default:              return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-data extension: sign- or zero-extends the assembled raw
// word according to the load op.
module lsu_load_ext
    import lsu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [OP_W-1:0] op,
    input  logic [W-1:0]    raw,
    output logic [W-1:0]    result
);

    // Pick the extension from the op; word loads and anything else pass through.
    always_comb begin
        result = raw;
        case (op)
            OP_LB:   result = {{(W-8){raw[7]}}, raw[7:0]};
            OP_LH:   result = {{(W-16){raw[15]}}, raw[15:0]};
            OP_LBU:  result = {{(W-8){1'b0}}, raw[7:0]};
            OP_LHU:  result = {{(W-16){1'b0}}, raw[15:0]};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store execution unit: takes one op from the LSB, walks it byte by byte
// over the memory-controller port, and broadcasts load results on the CDB.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int ROB_ID_W = 5
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                en_signal_from_lsb,
    input  logic [OP_W-1:0]     inst_name_from_lsb,
    input  logic [ADDR_W-1:0]   mem_addr_from_lsb,
    input  logic [ADDR_W-1:0]   store_value_from_lsb,
    input  logic [ROB_ID_W-1:0] rob_id_from_lsb,
    output logic                busy_to_lsb,
    output logic                valid_to_cdb,
    output logic [ADDR_W-1:0]   result_to_cdb,
    output logic [ROB_ID_W-1:0] rob_id_to_cdb,
    output logic                mem_en_to_mc,
    output logic                mem_wr_to_mc,
    output logic [ADDR_W-1:0]   mem_addr_to_mc,
    output logic [7:0]          mem_data_to_mc,
    input  logic [7:0]          mem_data_from_mc,
    input  logic                mem_done_from_mc,
    input  logic                rollback_flag_from_rob
);

    lsu_state_t          state_reg, state_next;
    logic [OP_W-1:0]     op_reg, op_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [ADDR_W-1:0]   store_reg, store_next;
    logic [ROB_ID_W-1:0] rob_reg, rob_next;
    logic [2:0]          idx_reg, idx_next;
    logic [2:0]          len_reg, len_next;
    logic                kill_reg, kill_next;

    logic [3:0]          lane_we;
    logic                result_clr;
    logic [ADDR_W-1:0]   result_raw;
    logic [ADDR_W-1:0]   result_ext;
    logic                op_is_load;
    logic                in_access;
    logic [7:0]          store_byte;

    assign op_is_load = is_load_op(op_reg);
    assign in_access  = (state_reg == ST_ACCESS);
    assign store_byte = store_reg[{idx_reg[1:0], 3'b000} +: 8];

    // Next-state and datapath-control logic for the byte sequencer.
    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        addr_next  = addr_reg;
        store_next = store_reg;
        rob_next   = rob_reg;
        idx_next   = idx_reg;
        len_next   = len_reg;
        kill_next  = kill_reg;
        lane_we    = 4'b0000;
        result_clr = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // A load racing a flush is speculative garbage; stores are
                // already committed and always go ahead.
                if (en_signal_from_lsb &&
                    !(is_load_op(inst_name_from_lsb) && rollback_flag_from_rob)) begin
                    op_next    = inst_name_from_lsb;
                    addr_next  = mem_addr_from_lsb;
                    store_next = store_value_from_lsb;
                    rob_next   = rob_id_from_lsb;
                    idx_next   = 3'd0;
                    len_next   = byte_count(inst_name_from_lsb);
                    kill_next  = 1'b0;
                    result_clr = 1'b1;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (op_is_load && rollback_flag_from_rob) begin
                    kill_next = 1'b1;
                end
                // The outstanding byte is always allowed to finish; a killed
                // load simply stops issuing further bytes.
                if (mem_done_from_mc) begin
                    if (op_is_load) begin
                        lane_we[idx_reg[1:0]] = 1'b1;
                    end
                    idx_next = idx_reg + 3'd1;
                    if ((idx_reg + 3'd1 == len_reg) || kill_next) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                kill_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Control and operand registers; a low rdy_in freezes everything.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg <= ST_IDLE;
            op_reg    <= '0;
            addr_reg  <= '0;
            store_reg <= '0;
            rob_reg   <= '0;
            idx_reg   <= '0;
            len_reg   <= '0;
            kill_reg  <= 1'b0;
        end else if (rdy_in) begin
            state_reg <= state_next;
            op_reg    <= op_next;
            addr_reg  <= addr_next;
            store_reg <= store_next;
            rob_reg   <= rob_next;
            idx_reg   <= idx_next;
            len_reg   <= len_next;
            kill_reg  <= kill_next;
        end
    end

    // One byte lane of the load result register per generated block; each
    // lane captures the returned byte when its index completes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_reg;

        // Capture returned read data into this lane.
        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                lane_reg <= 8'h00;
            end else if (rdy_in) begin
                if (result_clr) begin
                    lane_reg <= 8'h00;
                end else if (lane_we[gi]) begin
                    lane_reg <= mem_data_from_mc;
                end
            end
        end

        assign result_raw[gi*8 +: 8] = lane_reg;
    end

    if (ADDR_W > 32) begin : g_raw_hi
        assign result_raw[ADDR_W-1:32] = '0;
    end

    lsu_load_ext #(
        .W (ADDR_W)
    ) u_load_ext (
        .op     (op_reg),
        .raw    (result_raw),
        .result (result_ext)
    );

    // Outputs are decoded from registered state so reset forces them low and
    // a frozen unit keeps presenting the same values.
    assign busy_to_lsb    = rst_in && ((state_reg != ST_IDLE) || en_signal_from_lsb);
    assign mem_en_to_mc   = in_access;
    assign mem_wr_to_mc   = in_access && !op_is_load;
    assign mem_addr_to_mc = in_access ? (addr_reg + ADDR_W'(idx_reg)) : '0;
    assign mem_data_to_mc = (in_access && !op_is_load) ? store_byte : 8'h00;
    assign valid_to_cdb   = (state_reg == ST_DONE) && op_is_load &&
                            !kill_reg && !rollback_flag_from_rob;
    assign result_to_cdb  = valid_to_cdb ? result_ext : '0;
    assign rob_id_to_cdb  = valid_to_cdb ? rob_reg : '0;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load/store unit: drives inputs on the falling edge,
// checks outputs 1 ns later, and acts as a hand-scripted memory controller.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        en_signal_from_lsb = 1'b0;
    logic [5:0]  inst_name_from_lsb = '0;
    logic [31:0] mem_addr_from_lsb = '0;
    logic [31:0] store_value_from_lsb = '0;
    logic [4:0]  rob_id_from_lsb = '0;
    logic        busy_to_lsb;
    logic        valid_to_cdb;
    logic [31:0] result_to_cdb;
    logic [4:0]  rob_id_to_cdb;
    logic        mem_en_to_mc;
    logic        mem_wr_to_mc;
    logic [31:0] mem_addr_to_mc;
    logic [7:0]  mem_data_to_mc;
    logic [7:0]  mem_data_from_mc = '0;
    logic        mem_done_from_mc = 1'b0;
    logic        rollback_flag_from_rob = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    lsu dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .rdy_in                 (rdy_in),
        .en_signal_from_lsb     (en_signal_from_lsb),
        .inst_name_from_lsb     (inst_name_from_lsb),
        .mem_addr_from_lsb      (mem_addr_from_lsb),
        .store_value_from_lsb   (store_value_from_lsb),
        .rob_id_from_lsb        (rob_id_from_lsb),
        .busy_to_lsb            (busy_to_lsb),
        .valid_to_cdb           (valid_to_cdb),
        .result_to_cdb          (result_to_cdb),
        .rob_id_to_cdb          (rob_id_to_cdb),
        .mem_en_to_mc           (mem_en_to_mc),
        .mem_wr_to_mc           (mem_wr_to_mc),
        .mem_addr_to_mc         (mem_addr_to_mc),
        .mem_data_to_mc         (mem_data_to_mc),
        .mem_data_from_mc       (mem_data_from_mc),
        .mem_done_from_mc       (mem_done_from_mc),
        .rollback_flag_from_rob (rollback_flag_from_rob)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle, starting at a falling edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] val, input logic [4:0] rob, input logic rb);
        en_signal_from_lsb     = 1'b1;
        inst_name_from_lsb     = op;
        mem_addr_from_lsb      = addr;
        store_value_from_lsb   = val;
        rob_id_from_lsb        = rob;
        rollback_flag_from_rob = rb;
        #1;
        check("issue.busy", 32'(busy_to_lsb), 32'd1);
        check("issue.mem_en", 32'(mem_en_to_mc), 32'd0);
        @(negedge clk_in);
        en_signal_from_lsb     = 1'b0;
        rollback_flag_from_rob = 1'b0;
    endtask

    // Serve one byte access after `waits` stall cycles, checking the request is stable.
    task automatic serve_byte(input string tag, input logic [31:0] a, input logic wr,
                              input logic [7:0] wd, input logic [7:0] rd, input int waits);
        for (int w = 0; w <= waits; w++) begin
            mem_done_from_mc = (w == waits);
            mem_data_from_mc = (w == waits) ? rd : 8'h00;
            #1;
            $display("%s: cycle addr=0x%08h wr=%0d data=0x%02h done=%0d", tag,
                     mem_addr_to_mc, mem_wr_to_mc, mem_data_to_mc, mem_done_from_mc);
            check({tag, ".mem_en"}, 32'(mem_en_to_mc), 32'd1);
            check({tag, ".addr"}, mem_addr_to_mc, a);
            check({tag, ".wr"}, 32'(mem_wr_to_mc), 32'(wr));
            check({tag, ".wdata"}, 32'(mem_data_to_mc), 32'(wd));
            check({tag, ".busy"}, 32'(busy_to_lsb), 32'd1);
            check({tag, ".valid"}, 32'(valid_to_cdb), 32'd0);
            @(negedge clk_in);
        end
        mem_done_from_mc = 1'b0;
        mem_data_from_mc = 8'h00;
    endtask

    // DONE cycle of a load followed by the IDLE cycle.
    task automatic finish_load(input string tag, input logic [31:0] res, input logic [4:0] rob);
        #1;
        $display("%s: result valid=%0d data=0x%08h rob=%0d", tag, valid_to_cdb, result_to_cdb, rob_id_to_cdb);
        check({tag, ".valid"}, 32'(valid_to_cdb), 32'd1);
        check({tag, ".result"}, result_to_cdb, res);
        check({tag, ".rob"}, 32'(rob_id_to_cdb), 32'(rob));
        check({tag, ".done_mem_en"}, 32'(mem_en_to_mc), 32'd0);
        check({tag, ".done_busy"}, 32'(busy_to_lsb), 32'd1);
        @(negedge clk_in);
        #1;
        check({tag, ".idle_valid"}, 32'(valid_to_cdb), 32'd0);
        check({tag, ".idle_busy"}, 32'(busy_to_lsb), 32'd0);
        check({tag, ".idle_mem_en"}, 32'(mem_en_to_mc), 32'd0);
        @(negedge clk_in);
    endtask

    // DONE cycle of a store or killed load (no pulse), then IDLE.
    task automatic finish_quiet(input string tag);
        #1;
        $display("%s: done without result, valid=%0d", tag, valid_to_cdb);
        check({tag, ".valid"}, 32'(valid_to_cdb), 32'd0);
        check({tag, ".done_mem_en"}, 32'(mem_en_to_mc), 32'd0);
        check({tag, ".done_busy"}, 32'(busy_to_lsb), 32'd1);
        @(negedge clk_in);
        #1;
        check({tag, ".idle_busy"}, 32'(busy_to_lsb), 32'd0);
        check({tag, ".idle_valid"}, 32'(valid_to_cdb), 32'd0);
        @(negedge clk_in);
    endtask

    initial begin
        // Reset state
        @(negedge clk_in);
        #1;
        check("rst.busy", 32'(busy_to_lsb), 32'd0);
        check("rst.valid", 32'(valid_to_cdb), 32'd0);
        check("rst.result", result_to_cdb, 32'd0);
        check("rst.rob", 32'(rob_id_to_cdb), 32'd0);
        check("rst.mem_en", 32'(mem_en_to_mc), 32'd0);
        check("rst.mem_wr", 32'(mem_wr_to_mc), 32'd0);
        check("rst.mem_addr", mem_addr_to_mc, 32'd0);
        check("rst.mem_data", 32'(mem_data_to_mc), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);

        // LW, done every cycle: result in cycle 5
        issue(OP_LW, 32'h0000_1000, 32'h0, 5'd3, 1'b0);
        serve_byte("lw.b0", 32'h0000_1000, 1'b0, 8'h00, 8'h78, 0);
        serve_byte("lw.b1", 32'h0000_1001, 1'b0, 8'h00, 8'h56, 0);
        serve_byte("lw.b2", 32'h0000_1002, 1'b0, 8'h00, 8'h34, 0);
        serve_byte("lw.b3", 32'h0000_1003, 1'b0, 8'h00, 8'h12, 0);
        finish_load("lw", 32'h1234_5678, 5'd3);

        // LB / LBU / LH extension
        issue(OP_LB, 32'h0000_0020, 32'h0, 5'd1, 1'b0);
        serve_byte("lb.b0", 32'h0000_0020, 1'b0, 8'h00, 8'h80, 0);
        finish_load("lb", 32'hFFFF_FF80, 5'd1);
        issue(OP_LBU, 32'h0000_0020, 32'h0, 5'd2, 1'b0);
        serve_byte("lbu.b0", 32'h0000_0020, 1'b0, 8'h00, 8'h80, 0);
        finish_load("lbu", 32'h0000_0080, 5'd2);
        issue(OP_LH, 32'h0000_0030, 32'h0, 5'd7, 1'b0);
        serve_byte("lh.b0", 32'h0000_0030, 1'b0, 8'h00, 8'hFF, 0);
        serve_byte("lh.b1", 32'h0000_0031, 1'b0, 8'h00, 8'h7F, 1);
        finish_load("lh", 32'h0000_7FFF, 5'd7);

        // LHU across the top of the address space wraps to 0
        issue(OP_LHU, 32'hFFFF_FFFF, 32'h0, 5'd8, 1'b0);
        serve_byte("lhu.b0", 32'hFFFF_FFFF, 1'b0, 8'h00, 8'h34, 0);
        serve_byte("lhu.b1", 32'h0000_0000, 1'b0, 8'h00, 8'h92, 0);
        finish_load("lhu", 32'h0000_9234, 5'd8);

        // SH with two wait cycles per byte
        issue(OP_SH, 32'h0000_0104, 32'hAABB_CCDD, 5'd4, 1'b0);
        serve_byte("sh.b0", 32'h0000_0104, 1'b1, 8'hDD, 8'h00, 2);
        serve_byte("sh.b1", 32'h0000_0105, 1'b1, 8'hCC, 8'h00, 2);
        finish_quiet("sh");

        // LW killed by rollback on the second byte's done cycle
        issue(OP_LW, 32'h0000_0200, 32'h0, 5'd5, 1'b0);
        serve_byte("rb.b0", 32'h0000_0200, 1'b0, 8'h00, 8'h11, 0);
        mem_done_from_mc       = 1'b1;
        mem_data_from_mc       = 8'h22;
        rollback_flag_from_rob = 1'b1;
        #1;
        check("rb.b1.mem_en", 32'(mem_en_to_mc), 32'd1);
        check("rb.b1.addr", mem_addr_to_mc, 32'h0000_0201);
        @(negedge clk_in);
        mem_done_from_mc       = 1'b0;
        mem_data_from_mc       = 8'h00;
        rollback_flag_from_rob = 1'b0;
        finish_quiet("rb");
        issue(OP_LB, 32'h0000_0040, 32'h0, 5'd6, 1'b0);
        serve_byte("rb_lb.b0", 32'h0000_0040, 1'b0, 8'h00, 8'h7F, 0);
        finish_load("rb_lb", 32'h0000_007F, 5'd6);

        // rdy_in low holds the DONE pulse without repeating it afterwards
        issue(OP_LB, 32'h0000_0050, 32'h0, 5'd9, 1'b0);
        serve_byte("rdy.b0", 32'h0000_0050, 1'b0, 8'h00, 8'h85, 0);
        rdy_in = 1'b0;
        #1;
        check("rdy.valid0", 32'(valid_to_cdb), 32'd1);
        @(negedge clk_in);
        #1;
        check("rdy.valid1", 32'(valid_to_cdb), 32'd1);
        check("rdy.result", result_to_cdb, 32'hFFFF_FF85);
        rdy_in = 1'b1;
        @(negedge clk_in);
        #1;
        check("rdy.after_valid", 32'(valid_to_cdb), 32'd0);
        check("rdy.after_busy", 32'(busy_to_lsb), 32'd0);
        @(negedge clk_in);

        // Asynchronous reset in the middle of an SW
        issue(OP_SW, 32'h0000_0300, 32'h1122_3344, 5'd10, 1'b0);
        #1;
        check("arst.pre_mem_en", 32'(mem_en_to_mc), 32'd1);
        check("arst.pre_data", 32'(mem_data_to_mc), 32'h44);
        #2;
        rst_in = 1'b0;
        #1;
        $display("arst: mem_en=%0d wr=%0d addr=0x%08h busy=%0d", mem_en_to_mc, mem_wr_to_mc, mem_addr_to_mc, busy_to_lsb);
        check("arst.mem_en", 32'(mem_en_to_mc), 32'd0);
        check("arst.mem_wr", 32'(mem_wr_to_mc), 32'd0);
        check("arst.mem_addr", mem_addr_to_mc, 32'd0);
        check("arst.mem_data", 32'(mem_data_to_mc), 32'd0);
        check("arst.busy", 32'(busy_to_lsb), 32'd0);
        check("arst.valid", 32'(valid_to_cdb), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check("arst.rel_busy", 32'(busy_to_lsb), 32'd0);
        @(negedge clk_in);
        #1;
        check("arst.rel_mem_en", 32'(mem_en_to_mc), 32'd0);
        @(negedge clk_in);

        // LW together with rollback is dropped
        issue(OP_LW, 32'h0000_0500, 32'h0, 5'd11, 1'b1);
        #1;
        $display("drop: mem_en=%0d busy=%0d", mem_en_to_mc, busy_to_lsb);
        check("drop.mem_en", 32'(mem_en_to_mc), 32'd0);
        check("drop.busy", 32'(busy_to_lsb), 32'd0);
        @(negedge clk_in);

        // SW together with rollback is accepted and written
        issue(OP_SW, 32'h0000_0400, 32'hCAFE_BABE, 5'd12, 1'b1);
        serve_byte("sw.b0", 32'h0000_0400, 1'b1, 8'hBE, 8'h00, 0);
        serve_byte("sw.b1", 32'h0000_0401, 1'b1, 8'hBA, 8'h00, 1);
        serve_byte("sw.b2", 32'h0000_0402, 1'b1, 8'hFE, 8'h00, 0);
        serve_byte("sw.b3", 32'h0000_0403, 1'b1, 8'hCA, 8'h00, 0);
        finish_quiet("sw");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("FAIL timeout: observed no end of test, expected completion");
        $fatal(1, "timeout");
    end

endmodule
